// File: rtl/data_mem.sv
// data_mem: byte-addressable data memory stage behind the ALU.
// Serves lw/lh/lhu/lb/lbu/sw/sh/sb through a small IDLE/WAIT/ACCESS handshake
// with a configurable number of wait states.
//
// Handshake: i_req is sampled only in IDLE. An aligned request is latched and
// o_busy stays high until the access completes. Completion, or rejection of a
// misaligned request, is signalled by a one-cycle o_ready pulse, and rejection
// also raises o_misaligned. i_req seen while busy is dropped, not queued.
//
// Ports:
//   i_clk         clock; all state changes on the rising edge
//   i_rst_n       synchronous active-low reset
//   i_req         access request
//   i_mem_op      000 lw,001 lh,010 lhu,011 lb,100 lbu,101 sw,110 sh,111 sb
//   i_addr        effective byte address (low ADDR_WIDTH bits used)
//   i_wdata       store data
//   o_rdata       load result (held until the next completed load)
//   o_ready       one-cycle completion/rejection pulse
//   o_busy        request in flight
//   o_misaligned  one-cycle pulse with o_ready for a rejected request
//   o_state       current FSM state (debug)
module data_mem #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [2:0]  i_mem_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_misaligned,
  output logic [1:0]  o_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam bit         LP_HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_op;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_misaligned;

  // Memory contents are deliberately not reset.
  logic [7:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_word_op;
  logic                  w_half_op;
  logic                  w_misaligned;
  logic                  w_is_load;
  logic [ADDR_WIDTH-1:0] w_a0;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;
  logic [31:0]           w_load;
  logic                  w_unused_addr_hi;

  // Address bits above ADDR_WIDTH are ignored, so addresses wrap.
  assign w_unused_addr_hi = ^i_addr[31:ADDR_WIDTH];

  assign w_word_op    = (i_mem_op == OP_LW) || (i_mem_op == OP_SW);
  assign w_half_op    = (i_mem_op == OP_LH) || (i_mem_op == OP_LHU) || (i_mem_op == OP_SH);
  assign w_misaligned = (w_word_op && (i_addr[1:0] != 2'b00)) || (w_half_op && i_addr[0]);
  assign w_is_load    = (r_op <= OP_LBU);

  // Only aligned requests are latched, so the lane addresses are formed by
  // replacing the low bits instead of adding an offset.
  assign w_a0 = r_addr;
  assign w_a1 = {r_addr[ADDR_WIDTH-1:1], 1'b1};
  assign w_a2 = {r_addr[ADDR_WIDTH-1:2], 2'b10};
  assign w_a3 = {r_addr[ADDR_WIDTH-1:2], 2'b11};

  assign w_b0 = r_mem[w_a0];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  always_comb begin
    w_load = 32'd0;
    case (r_op)
      OP_LW:   w_load = {w_b3, w_b2, w_b1, w_b0};
      OP_LH:   w_load = {{16{w_b1[7]}}, w_b1, w_b0};
      OP_LHU:  w_load = {16'd0, w_b1, w_b0};
      OP_LB:   w_load = {{24{w_b0[7]}}, w_b0};
      OP_LBU:  w_load = {24'd0, w_b0};
      default: w_load = 32'd0;
    endcase
  end

  // Store commit happens on the ACCESS edge; reset on the same edge wins.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (r_state == S_ACCESS)) begin
      case (r_op)
        OP_SW: begin
          r_mem[w_a0] <= r_wdata[7:0];
          r_mem[w_a1] <= r_wdata[15:8];
          r_mem[w_a2] <= r_wdata[23:16];
          r_mem[w_a3] <= r_wdata[31:24];
        end
        OP_SH: begin
          r_mem[w_a0] <= r_wdata[7:0];
          r_mem[w_a1] <= r_wdata[15:8];
        end
        OP_SB: begin
          r_mem[w_a0] <= r_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_op         <= 3'd0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_ready      <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            if (w_misaligned) begin
              r_ready      <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
              r_addr  <= i_addr[ADDR_WIDTH-1:0];
              r_op    <= i_mem_op;
              r_wdata <= i_wdata;
              r_busy  <= 1'b1;
              r_cnt   <= LP_WAIT_LOAD;
              r_state <= LP_HAS_WAIT ? S_WAIT : S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (w_is_load) begin
            r_rdata <= w_load;
          end
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdata      = r_rdata;
  assign o_ready      = r_ready;
  assign o_busy       = r_busy;
  assign o_misaligned = r_misaligned;
  assign o_state      = r_state;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem (ADDR_WIDTH=12, WAIT_STATES=1). A transaction-level model
// tracks expected outputs cycle by cycle; directed accesses add literal checks.
module tb_data_mem;

  localparam int AW = 12;
  localparam int WS = 1;
  localparam int N_BYTES = 1 << AW;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misaligned;
  logic [1:0]  state;

  always #5 clk = ~clk;

  data_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mem_op(mem_op),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
    .o_busy(busy), .o_misaligned(misaligned), .o_state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Memory as a byte array; an in-flight request is just a count of edges
  // until it completes (WS+1 after acceptance).
  logic [7:0]  mm [0:N_BYTES-1];
  logic [31:0] m_rdata = 32'd0;
  logic        m_ready = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_mis   = 1'b0;
  int          m_left  = 0;
  int          m_base  = 0;
  logic [2:0]  m_op    = 3'd0;
  logic [31:0] m_wd    = 32'd0;

  function automatic bit model_misaligned(input logic [2:0] op, input logic [31:0] a);
    if ((op == OP_LW || op == OP_SW) && (a % 4 != 0)) return 1'b1;
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_access();
    int v;
    int nst;
    nst = (m_op == OP_SW) ? 4 : (m_op == OP_SH) ? 2 : (m_op == OP_SB) ? 1 : 0;
    for (int k = 0; k < nst; k++) mm[(m_base + k) % N_BYTES] = 8'(m_wd >> (8 * k));
    case (m_op)
      OP_LW: begin
        v = 0;
        for (int k = 3; k >= 0; k--) v = v * 256 + int'(mm[(m_base + k) % N_BYTES]);
        m_rdata = 32'(v);
      end
      OP_LH, OP_LHU: begin
        v = int'(mm[m_base]) + 256 * int'(mm[(m_base + 1) % N_BYTES]);
        if (m_op == OP_LH && v >= 32768) v = v - 65536;
        m_rdata = 32'(v);
      end
      OP_LB, OP_LBU: begin
        v = int'(mm[m_base]);
        if (m_op == OP_LB && v >= 128) v = v - 256;
        m_rdata = 32'(v);
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rdata = 32'd0; m_ready = 1'b0; m_busy = 1'b0; m_mis = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_ready = 1'b0;
      m_mis   = 1'b0;
      if (m_left == 0) begin
        model_access();
        m_ready = 1'b1;
        m_busy  = 1'b0;
      end else begin
        m_busy = 1'b1;
      end
    end else begin
      m_ready = 1'b0; m_mis = 1'b0; m_busy = 1'b0;
      if (req) begin
        if (model_misaligned(mem_op, addr)) begin
          m_ready = 1'b1; m_mis = 1'b1;
        end else begin
          m_base = int'(addr % N_BYTES);
          m_op   = mem_op;
          m_wd   = wdata;
          m_left = WS + 1;
          m_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("rdata", rdata, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] last_rd;
  logic        last_mis;

  // Issue one request; afterwards the inputs are scrambled to show the
  // latched copies are used. Optionally pulse a stray sw 0x40 while busy.
  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input bit inject);
    bit done;
    int lat;
    int nbusy;
    bit exp_mis;
    done = 1'b0; lat = -1; nbusy = 0;
    exp_mis = model_misaligned(op, a);
    @(negedge clk);
    req = 1'b1; mem_op = op; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; mem_op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nbusy++;
      if (ready) begin
        done = 1'b1; lat = i; last_rd = rdata; last_mis = misaligned;
      end else begin
        if (inject && i == 0) begin
          req = 1'b1; mem_op = OP_SW; addr = 32'h40; wdata = 32'h0BADBAD0;
        end
        @(negedge clk);
        req = 1'b0;
      end
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_lat"}, 32'(lat), exp_mis ? 32'd0 : 32'(WS + 1));
    chk({name, "_busycyc"}, 32'(nbusy), exp_mis ? 32'd0 : 32'(WS + 1));
    chk({name, "_mis"}, 32'(last_mis), 32'(exp_mis));
  endtask

  // Start sw, then assert reset so it lands on edge T+1+extra after acceptance.
  task automatic sw_reset(input string name, input logic [31:0] a, input logic [31:0] d,
                          input int extra);
    @(negedge clk);
    req = 1'b1; mem_op = OP_SW; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    repeat (extra) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk({name, "_ready0"}, 32'(ready), 32'd0);
    chk({name, "_busy0"}, 32'(busy), 32'd0);
    chk({name, "_mis0"}, 32'(misaligned), 32'd0);
    chk({name, "_rdata0"}, rdata, 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int extra_ready;
    rst_n = 1'b0; req = 1'b0; mem_op = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    run("sw10", OP_SW, 32'h10, 32'hDEADBEEF, 1'b0);
    run("lw10", OP_LW, 32'h10, 32'h0, 1'b0);
    chk("lw10_val", last_rd, 32'hDEADBEEF);
    run("lb13", OP_LB, 32'h13, 32'h0, 1'b0);
    chk("lb13_val", last_rd, 32'hFFFFFFDE);
    run("lbu13", OP_LBU, 32'h13, 32'h0, 1'b0);
    chk("lbu13_val", last_rd, 32'h000000DE);
    run("lh10", OP_LH, 32'h10, 32'h0, 1'b0);
    chk("lh10_val", last_rd, 32'hFFFFBEEF);
    run("lhu12", OP_LHU, 32'h12, 32'h0, 1'b0);
    chk("lhu12_val", last_rd, 32'h0000DEAD);

    run("sb11", OP_SB, 32'h11, 32'h00000055, 1'b0);
    run("lw10b", OP_LW, 32'h10, 32'h0, 1'b0);
    chk("lw10b_val", last_rd, 32'hDEAD55EF);
    run("sh12", OP_SH, 32'h12, 32'h00001234, 1'b0);
    run("lw10c", OP_LW, 32'h10, 32'h0, 1'b0);
    chk("lw10c_val", last_rd, 32'h123455EF);

    run("mis_lw13", OP_LW, 32'h13, 32'h0, 1'b0);
    chk("mis_lw13_rd", last_rd, 32'h123455EF);
    run("mis_sh11", OP_SH, 32'h11, 32'hFFFF, 1'b0);
    run("mis_sw22", OP_SW, 32'h22, 32'hFFFFFFFF, 1'b0);
    run("lw10d", OP_LW, 32'h10, 32'h0, 1'b0);
    chk("lw10d_val", last_rd, 32'h123455EF);

    run("sw1004", OP_SW, 32'h00001004, 32'hCAFEF00D, 1'b0);
    run("lw004", OP_LW, 32'h00000004, 32'h0, 1'b0);
    chk("wrap_val", last_rd, 32'hCAFEF00D);

    run("sw40", OP_SW, 32'h40, 32'hA5A5A5A5, 1'b0);
    run("sw44_inj", OP_SW, 32'h44, 32'h77777777, 1'b1);
    extra_ready = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready) extra_ready++;
    end
    chk("ignored_req_ready", 32'(extra_ready), 32'd0);
    run("lw40", OP_LW, 32'h40, 32'h0, 1'b0);
    chk("lw40_val", last_rd, 32'hA5A5A5A5);
    run("lw44", OP_LW, 32'h44, 32'h0, 1'b0);
    chk("lw44_val", last_rd, 32'h77777777);

    run("sw20", OP_SW, 32'h20, 32'h11111111, 1'b0);
    sw_reset("rst_wait", 32'h20, 32'h22222222, 0);
    run("lw20", OP_LW, 32'h20, 32'h0, 1'b0);
    chk("lw20_val", last_rd, 32'h11111111);
    sw_reset("rst_access", 32'h20, 32'h33333333, 1);
    run("lw20b", OP_LW, 32'h20, 32'h0, 1'b0);
    chk("lw20b_val", last_rd, 32'h11111111);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t got=running exp=finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable data memory stage for the MIPS datapath. It sits directly downstream of the ALU. It takes the ALU `result` as the effective address and the rt register value as store data, and performs lw/lh/lhu/lb/lbu/sw/sh/sb. Each access runs through a small handshake state machine with configurable wait states, so the control unit stalls on `busy` and resumes on `ready`.

## Interface
- `ADDR_WIDTH`, default 12: byte-address bits used. Memory holds 2^ADDR_WIDTH bytes.
- `WAIT_STATES`, default 1: extra cycles inserted between request acceptance and access (0–15).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  1  access request; sampled only in IDLE.
- `mem_op`  in  3  operation code:
  - 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
  - 101 sw, 110 sh, 111 sb
- `addr`  in  32  effective byte address (ALU result).
- `wdata`  in  32  store data (rt).
- `rdata`  out  32  load result, sign- or zero-extended per op.
- `ready`  out  1  one-cycle pulse: access completed or rejected.
- `busy`  out  1  high while a request is in flight.
- `misaligned`  out  1  one-cycle pulse with `ready` when the address is misaligned.

## Operation
- States: IDLE, WAIT, ACCESS.
- IDLE, `req`=0: stay; `busy`=0.
- IDLE, `req`=1, misaligned: stay in IDLE.
  - Misaligned means word op with addr[1:0]≠0, or half op with addr[0]≠0.
  - Next cycle `ready`=1 and `misaligned`=1.
  - No memory write; `rdata` unchanged.
- IDLE, `req`=1, aligned:
  - Latch addr, mem_op and wdata; set `busy`=1.
  - Go to WAIT if WAIT_STATES>0, else to ACCESS.
- WAIT: down-counter loaded with WAIT_STATES−1; decrement each cycle; go to ACCESS when it reaches 0.
- ACCESS: perform the access, pulse `ready`, clear `busy`, return to IDLE.
- Address decoding: only addr[ADDR_WIDTH-1:0] is used; upper bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH.
- Byte order is little-endian: byte k of a word sits at address base+k.
- Stores:
  - sw writes 4 bytes.
  - sh writes wdata[15:0] to addr, addr+1.
  - sb writes wdata[7:0] to addr.
  - Other bytes are untouched.
- Loads:
  - lw returns 4 bytes.
  - lh/lb sign-extend from bit 15/7.
  - lhu/lbu zero-extend.
- `rdata` holds its value until the next completed load. Stores and rejected requests do not change it.
- `req` asserted while `busy`=1 is ignored and not queued.
- Memory array contents are not reset. Reading a never-written location returns undefined data; benches must write first.

## Timing
- Reset values: `rdata`=0, `ready`=0, `busy`=0, `misaligned`=0, state IDLE, counter 0.
- All outputs are registered.
- Request accepted at edge T:
  - `busy`=1 from T through T+WAIT_STATES.
  - `ready`=1 in cycle T+WAIT_STATES+1 only, with `busy`=0 in that cycle.
  - With WAIT_STATES=0: `busy` high for 1 cycle; `ready` in the cycle after acceptance.
- Store commit happens at the ACCESS edge. A load's `rdata` is valid in the same cycle `ready`=1.
- Misaligned rejection: `ready`/`misaligned` high one cycle after the request edge; `busy` never rises.
- Back-to-back requests:
  - In the cycle `ready`=1 the FSM is in IDLE, so `req` high in that cycle is accepted.
  - Maximum throughput is one access per WAIT_STATES+2 cycles.
- `rst_n`=0 at any edge forces the reset values. A store still in WAIT is aborted and not committed. A store whose ACCESS edge coincides with reset is also not committed: reset has priority.
- `addr`, `wdata` and `mem_op` may change freely after acceptance; the latched copies are used.

## Test plan
- WAIT_STATES=1: sw addr 0x10 wdata 0xDEADBEEF, then lw addr 0x10 -> `ready` 2 cycles after each accept; `rdata`=0xDEADBEEF; `busy` high exactly 2 cycles per access.
- After the word above: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- sb 0x11 wdata 0x00000055, then lw 0x10 -> 0xDEAD55EF. sh 0x12 wdata 0x1234, then lw 0x10 -> 0x123455EF.
- lw 0x13, sh 0x11, sw 0x22 -> each gives `ready`=`misaligned`=1 one cycle after the request; `busy` stays 0; memory and `rdata` unchanged.
- ADDR_WIDTH=12: sw 0x00001004 wdata 0xCAFEF00D, then lw 0x00000004 -> 0xCAFEF00D (wrap). `req` pulsed while `busy` -> ignored, exactly one `ready`.
- sw 0x20 wdata 0x11111111 completed. Then sw 0x20 wdata 0x22222222 with `rst_n`=0 during WAIT -> all outputs 0 next cycle. A following lw 0x20 -> 0x11111111.
